// File: rtl/axi_line_master.sv
// AXI initiator turning single cache-line requests into fixed-length, aligned, full-width INCR bursts.
// Optional AXI_LINE_MASTER_PROTOCOL_CHECK_EN adds rlast/rid/bid checking folded into resp_err.
module axi_line_master #(
  parameter int DATA_W                = 64,
  parameter int ADDR_W                = 64,
  parameter int FIXED_NUMBER_OF_BEATS = 16,
  parameter int AXI_ID                = 0,
  localparam int LINE_W               = DATA_W * FIXED_NUMBER_OF_BEATS,
  localparam int ID_W                 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // cache-side request / response
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LINE_W-1:0]   req_wline,
  output logic                resp_valid,
  output logic [LINE_W-1:0]   resp_rline,
  output logic                resp_err,
  // AW / W / B
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [ID_W-1:0]     awid,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  input  logic [ID_W-1:0]     bid,
  // AR / R
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [ID_W-1:0]     arid,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic [ID_W-1:0]     rid
);
  localparam int N      = FIXED_NUMBER_OF_BEATS;
  localparam int BEAT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((LINE_W / 8) - 1);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, W, B, RESP} state_t;

  state_t              state_reg, state_next;
  logic [BEAT_W-1:0]   beat_reg, beat_next;
  logic                err_reg, err_next;
  logic                aw_done_reg, aw_done_next;
  logic                w0_done_reg, w0_done_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [LINE_W-1:0]   line_reg, line_merged;
  logic [LINE_W-1:0]   rline_reg;
  logic                is_last, proto_err;
  logic                r_hs, w_hs, aw_hs, b_hs;

  assign is_last = (beat_reg == LAST_BEAT);
  assign r_hs    = rvalid && rready;
  assign w_hs    = wvalid && wready;
  assign aw_hs   = awvalid && awready;
  assign b_hs    = bvalid && bready;

  assign req_ready  = rst_n && (state_reg == IDLE);
  assign resp_valid = (state_reg == RESP);
  assign resp_err   = resp_valid && err_reg;
  assign resp_rline = rline_reg;

  assign awvalid = (state_reg == AW_W) && !aw_done_reg;
  assign wvalid  = ((state_reg == AW_W) && !w0_done_reg) || (state_reg == W);
  assign wdata   = line_reg[beat_reg*DATA_W +: DATA_W];
  assign wlast   = wvalid && is_last;
  assign wstrb   = '1;
  assign bready  = (state_reg == B);
  assign arvalid = (state_reg == AR);
  assign rready  = (state_reg == R);

  assign awaddr  = addr_reg;
  assign araddr  = addr_reg;
  assign awlen   = 8'(N - 1);
  assign arlen   = 8'(N - 1);
  assign awsize  = 3'($clog2(DATA_W / 8));
  assign arsize  = 3'($clog2(DATA_W / 8));
  assign awburst = 2'b01;
  assign arburst = 2'b01;
  assign awid    = ID_W'(AXI_ID);
  assign arid    = ID_W'(AXI_ID);

`ifdef AXI_LINE_MASTER_PROTOCOL_CHECK_EN
  always_comb begin
    proto_err = 1'b0;
    if (r_hs && ((rlast != is_last) || (rid != ID_W'(AXI_ID))))
      proto_err = 1'b1;
    if (b_hs && (bid != ID_W'(AXI_ID)))
      proto_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_n && proto_err)
      $error("axi_line_master: protocol error at beat %0d", beat_reg);
  end
`else
  logic unused_proto;
  assign unused_proto = ^{rlast, rid, bid};
  assign proto_err    = 1'b0;
`endif

  // Incoming read beat merged into its slot; also feeds resp_rline on the last beat.
  always_comb begin
    line_merged = line_reg;
    line_merged[beat_reg*DATA_W +: DATA_W] = rdata;
  end

  always_comb begin
    state_next   = state_reg;
    beat_next    = beat_reg;
    err_next     = err_reg;
    aw_done_next = aw_done_reg;
    w0_done_next = w0_done_reg;
    case (state_reg)
      IDLE: if (req_valid) state_next = req_write ? AW_W : AR;
      AR: if (arready) begin
        state_next = R;
        beat_next  = '0;
      end
      R: if (r_hs) begin
        err_next  = err_reg | (rresp != 2'b00) | proto_err;
        beat_next = beat_reg + 1'b1;
        if (is_last) state_next = RESP;
      end
      AW_W: begin
        if (aw_hs) aw_done_next = 1'b1;
        if (w_hs)  w0_done_next = 1'b1;
        if ((aw_done_reg || aw_hs) && (w0_done_reg || w_hs)) begin
          aw_done_next = 1'b0;
          w0_done_next = 1'b0;
          if (N == 1) begin
            state_next = B;
          end else begin
            state_next = W;
            beat_next  = BEAT_W'(1);
          end
        end
      end
      W: if (w_hs) begin
        beat_next = beat_reg + 1'b1;
        if (is_last) state_next = B;
      end
      B: if (b_hs) begin
        err_next   = err_reg | (bresp != 2'b00) | proto_err;
        state_next = RESP;
      end
      RESP: begin
        err_next   = 1'b0;
        beat_next  = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      beat_reg    <= '0;
      err_reg     <= 1'b0;
      aw_done_reg <= 1'b0;
      w0_done_reg <= 1'b0;
      rline_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      beat_reg    <= beat_next;
      err_reg     <= err_next;
      aw_done_reg <= aw_done_next;
      w0_done_reg <= w0_done_next;
      if (r_hs && is_last)
        rline_reg <= line_merged;
    end
  end

  // Line buffer holds the write line, or collects read beats; no reset needed.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && req_valid) begin
      addr_reg <= req_addr & ~OFF_MASK;
      line_reg <= req_wline;
    end else if (r_hs) begin
      line_reg <= line_merged;
    end
  end

endmodule
